// File: rtl/display_pkg.sv
// Shared constants, shadow-register state encoding and blanking helper for the digit scanner.
package display_pkg;

  localparam int unsigned NUM_DIGITS      = 8;
  localparam int unsigned DIGIT_W         = 4;
  localparam int unsigned BCD_W           = NUM_DIGITS * DIGIT_W;
  localparam int unsigned ANUM_W          = 3;
  localparam int unsigned CLK_DIV_DEFAULT = 100000;

  typedef enum logic {
    SHADOW_EMPTY = 1'b0,
    SHADOW_FULL  = 1'b1
  } shadow_state_e;

  // Bit k set when any of digits k..NUM_DIGITS-1 is non-zero; digit 0 is always lit.
  function automatic logic [NUM_DIGITS-1:0] lit_mask(input logic [BCD_W-1:0] digits);
    logic [NUM_DIGITS-1:0] mask;
    logic                  any_nz;
    mask   = '0;
    any_nz = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      any_nz  = any_nz | (|digits[k*DIGIT_W +: DIGIT_W]);
      mask[k] = any_nz;
    end
    mask[0] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running divider: counts 0..CLK_DIV-1 and flags the last count as the digit-advance tick.
module scan_prescaler
  import display_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned      CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/digit_scan_controller.sv
// Eight-digit BCD scan controller with a one-deep shadow register that only updates the display at frame boundaries.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module digit_scan_controller
  import display_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BCD_W-1:0]  bcd_in,
  input  logic              load_valid,
  output logic              load_ready,
  output logic [DIGIT_W-1:0] v,
  output logic [ANUM_W-1:0] anum,
  output logic              digit_on,
  output logic              frame_start
);

  localparam logic [ANUM_W-1:0] ANUM_LAST = ANUM_W'(NUM_DIGITS - 1);

  logic          tick;
  logic          wrap;
  shadow_state_e state;
  logic [BCD_W-1:0] shadow_reg;
  logic [BCD_W-1:0] display_reg;

  scan_prescaler #(
    .CLK_DIV(CLK_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign wrap = tick && (anum == ANUM_LAST);

  // Digit index and frame pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      anum        <= '0;
      frame_start <= 1'b0;
    end else begin
      if (tick) begin
        anum <= anum + ANUM_W'(1);
      end
      frame_start <= wrap;
    end
  end

  // Shadow handshake: a load accepted on the wrap cycle itself waits for the next wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SHADOW_EMPTY;
      shadow_reg  <= '0;
      display_reg <= '0;
    end else begin
      case (state)
        SHADOW_EMPTY: begin
          if (load_valid) begin
            shadow_reg <= bcd_in;
            state      <= SHADOW_FULL;
          end
        end
        SHADOW_FULL: begin
          if (wrap) begin
            display_reg <= shadow_reg;
            state       <= SHADOW_EMPTY;
          end
        end
        default: state <= SHADOW_EMPTY;
      endcase
    end
  end

  assign load_ready = (state == SHADOW_EMPTY) && !rst;
  assign v          = display_reg[anum*DIGIT_W +: DIGIT_W];

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lit;
  assign lit      = lit_mask(display_reg);
  assign digit_on = lit[anum];
`else
  assign digit_on = 1'b1;
`endif

endmodule

// File: tb/tb_digit_scan_controller.sv
// Self-checking bench for digit_scan_controller at CLK_DIV=4; accepted loads queue up until their frame boundary.
module tb_digit_scan_controller;

  localparam int unsigned DIV = 4;

  logic        clk;
  logic        rst;
  logic [31:0] bcd_in;
  logic        load_valid;
  logic        load_ready;
  logic [3:0]  v;
  logic [2:0]  anum;
  logic        digit_on;
  logic        frame_start;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  int          errors = 0;
  int          checks = 0;
  int          c      = 0;
  logic [31:0] disp_m = '0;
  bit          full_m = 1'b0;
  logic [31:0] pend_q[$];

  digit_scan_controller #(
    .CLK_DIV(DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .v          (v),
    .anum       (anum),
    .digit_on   (digit_on),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, c, got, exp);
    end
  endtask

  function automatic bit exp_on(input logic [31:0] d, input int k);
    return !(BLANK_EN && (k != 0) && ((d >> (4 * k)) == 32'd0));
  endfunction

  // One clock cycle: drive, compare, advance the reference model.
  task automatic step(input logic lv, input logic [31:0] d, output bit acc);
    int ae;
    @(negedge clk);
    load_valid = lv;
    bcd_in     = d;
    #1;
    ae = (c / DIV) % 8;
    check("load_ready", 32'(load_ready), 32'(!full_m));
    check("anum", 32'(anum), 32'(ae));
    check("frame_start", 32'(frame_start), 32'((c > 0) && (c % (8 * DIV) == 0)));
    check("v", 32'(v), 32'(disp_m[4*ae +: 4]));
    check("digit_on", 32'(digit_on), 32'(exp_on(disp_m, ae)));
    acc = lv && !full_m;
    if (full_m && (c % (8 * DIV) == 8 * DIV - 1)) begin
      disp_m = pend_q.pop_front();
      full_m = 1'b0;
    end else if (acc) begin
      pend_q.push_back(d);
      full_m = 1'b1;
    end
    @(posedge clk);
    c++;
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) step(1'b0, bcd_in, a);
  endtask

  task automatic load(input logic [31:0] d);
    bit a;
    int n;
    a = 1'b0;
    n = 0;
    while (!a && n < 200) begin
      step(1'b1, d, a);
      n++;
    end
    check("load_accept", 32'(a), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    load_valid = 1'b0;
    #1;
    check("load_ready_in_rst", 32'(load_ready), 32'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    c      = 0;
    disp_m = '0;
    full_m = 1'b0;
    pend_q.delete();
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    bcd_in     = '0;
    repeat (2) @(posedge clk);
    do_reset();
    idle(70);

    load(32'h8765_4321);
    idle(80);

    load(32'h1111_1111);
    load(32'h2222_2222);
    idle(90);

    load(32'hFEDC_BA98);
    idle(70);

    load(32'h0000_0305);
    idle(70);
    load(32'h0000_0000);
    idle(70);

    // Reset while the shadow holds a value and the scan sits at digit 5
    while (c % (8 * DIV) != 4) idle(1);
    load(32'h9999_9999);
    while (c % (8 * DIV) != 20) idle(1);
    do_reset();
    idle(70);

    // Load landing exactly on the 7->0 tick
    while (c % (8 * DIV) != 8 * DIV - 1) idle(1);
    load(32'h3141_5926);
    idle(80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
